fifo_rd_stream: RTL
===================

# fifo_rd_stream

Read-side streaming engine placed directly downstream of `sync_fifo`. It pops the FIFO whenever downstream buffer space exists, absorbs the FIFO's one-cycle read latency in a small internal buffer, and presents the data as a valid/ready stream framed into fixed-length bursts. It also reports FIFO error events and keeps an accepted-beat count for the scoreboard and coverage.

## Interface
Parameters:
- `DATA_W`, default 8: width of FIFO read data and of the output stream.
- `BUF_DEPTH`, default 3: internal buffer entries. Minimum 3 for full throughput; legal values are 3..8.
- `BURST_LEN`, default 4: beats per burst. `m_last_o` asserts on the final beat of each burst. Legal values are 1..256.

Ports:
- `clk_i`, in, 1: single clock. All logic is rising-edge.
- `rst_i`, in, 1: reset, asynchronous assert, active-low (0 = in reset). Deassertion is synchronised externally.
- `en_i`, in, 1: run enable.
- `fifo_rdata_i`, in, DATA_W: FIFO read data, valid one cycle after `fifo_rd_en_o`.
- `fifo_empty_i`, in, 1: FIFO empty flag.
- `fifo_error_i`, in, 1: FIFO error flag.
- `fifo_rd_en_o`, out, 1: FIFO pop request.
- `m_data_o`, out, DATA_W: stream data.
- `m_valid_o`, out, 1: stream valid.
- `m_last_o`, out, 1: final beat of the current burst.
- `m_ready_i`, in, 1: downstream ready.
- `busy_o`, out, 1: state is not IDLE.
- `err_o`, out, 1: sticky error flag.
- `clr_err_i`, in, 1: clears `err_o`.
- `beat_cnt_o`, out, 16: number of accepted beats. Wraps modulo 2^16.

## Operation
- Internal state:
  - `occ`: buffer occupancy, 0..BUF_DEPTH.
  - `inflight`: 1 if a pop was issued last cycle.
  - `burst_idx`: position within the burst, 0..BURST_LEN-1.
- Pop rule, combinational: `fifo_rd_en_o = (state==RUN) && en_i && !fifo_empty_i && (occ + inflight < BUF_DEPTH)`. `occ` and `inflight` are register values.
  - The rule does not depend on `m_ready_i`.
  - The buffer can never overflow.
  - The block never pops an empty FIFO.
- Capture: when `inflight==1`, `fifo_rdata_i` is written at the buffer tail on that clock edge.
- Accept: a beat is accepted when `m_valid_o && m_ready_i`. On accept:
  - the head entry is popped;
  - `burst_idx` increments, wrapping to 0 after BURST_LEN-1;
  - `beat_cnt_o` increments.
- A simultaneous capture and accept leaves `occ` unchanged.
- `m_valid_o = (occ != 0)`.
- `m_data_o` is the head entry. It holds stable while valid and not accepted.
- `m_last_o = m_valid_o && (burst_idx == BURST_LEN-1)`.
- FSM states: IDLE, RUN, DRAIN. Encoding is held in the package.
  - IDLE → RUN when `en_i`=1.
  - RUN → DRAIN when `en_i`=0 and (`occ`!=0 or `inflight`).
  - RUN → IDLE when `en_i`=0 and the buffer is empty with nothing in flight.
  - DRAIN → IDLE when `occ`=0, `inflight`=0 and no accept is pending.
  - DRAIN → RUN if `en_i` reasserts. In-flight data and buffered data are preserved.
  - No pops are issued in DRAIN. Buffered beats keep streaming out.
- Burst alignment survives en_i toggling: `burst_idx` resets only on reset.
- `err_o` sets on any cycle with `fifo_error_i`=1.
  - `err_o` clears on `clr_err_i`=1.
  - If set and clear occur in the same cycle, set wins.
  - Data flow is unaffected by the error flag.

## Timing
- Reset values:
  - All outputs are 0.
  - `occ`=0, `inflight`=0, `burst_idx`=0, state=IDLE.
  - Buffer contents are don't-care.
- Reset mid-operation: the async clear discards buffered and in-flight data. A FIFO word that the FIFO returns after reset is ignored.
- Latency: `fifo_rd_en_o` high in cycle N gives `m_valid_o` high in cycle N+2 with that word, provided the buffer was empty.
- Throughput: 1 beat per cycle sustained with `m_ready_i`=1 and the FIFO non-empty.
- Backpressure: with `m_ready_i` held at 0, exactly BUF_DEPTH pops are issued, then `fifo_rd_en_o` stays 0.
- FIFO goes empty mid-stream: pops stop the same cycle. The buffer then drains and `m_valid_o` drops after the last buffered beat.
- Start-up: the first cycle with `en_i`=1 moves IDLE → RUN. Pops begin the following cycle.

## Structure
- Package `fifo_rd_pkg` holds:
  - the state enum `rd_state_e` (IDLE, RUN, DRAIN);
  - the defaults `DATA_W`, `BUF_DEPTH`, `BURST_LEN`;
  - the constant `CNT_W`=16.
- One sub-module, `fifo_rd_skid_buf`:
  - BUF_DEPTH-entry circular buffer with wrapping head/tail pointers and an `occ` counter;
  - push, pop and simultaneous push+pop ports;
  - head data output.
- The top level holds the FSM, the credit/pop logic, the burst counter, the beat counter and the error flag.

## Test plan
- Reset: with `rst_i`=0, every output is 0. After release with `en_i`=0, `fifo_rd_en_o` stays 0 for 20 cycles.
- Streaming: FIFO holds 8 words 0x10..0x17, `m_ready_i`=1, `en_i`=1.
  - 8 consecutive beats 0x10..0x17 appear, the first at pop cycle +2.
  - `m_last_o` is high on 0x13 and 0x17.
  - `beat_cnt_o`=8.
- Backpressure: FIFO holds 6 words, `m_ready_i`=0 for 10 cycles, then 1.
  - Exactly 3 pops occur during the stall.
  - All 6 words arrive in order; none lost or duplicated.
- Enable drop: `en_i` falls after 2 beats with 2 words buffered.
  - The FSM goes to DRAIN and no further pops occur.
  - The 2 buffered words are delivered, then IDLE and `busy_o`=0.
  - Re-enabling continues the burst, with `m_last_o` on the next burst-final beat.
- Error: pulse `fifo_error_i` for 1 cycle.
  - `err_o` rises next cycle and stays high.
  - `clr_err_i` clears it; clear coincident with a new error keeps it at 1.
- Mid-stream reset: assert `rst_i` with 3 words buffered and a pop in flight.
  - Outputs are 0 immediately.
  - After release, `beat_cnt_o`=0 and the first burst's `m_last_o` falls on beat 4.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and default parameters for the
// FIFO read-side streaming engine.
package fifo_rd_pkg;

    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 3;
    localparam int BURST_LEN = 4;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready output stream of fifo_rd_stream.
// Ports: data/valid/last from master, ready from slave.
interface fifo_rd_stream_if #(
    parameter int DATA_W = fifo_rd_pkg::DATA_W
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              last;
    logic              ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: DEPTH-entry circular buffer with occupancy count.
// Ports: clk_i, rst_i (async, active-low), push_i/push_data_i,
//        pop_i, head_o (oldest entry), occ_o (entries held).
module fifo_rd_skid_buf #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 3,
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [OCC_W-1:0]  occ_o
);
    import fifo_rd_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(
        input logic [PTR_W-1:0] p
    );
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push_i) tail_d = ptr_inc(tail_q);
        if (pop_i)  head_d = ptr_inc(head_q);
        unique case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[tail_q] <= push_data_i;
    end

    assign head_o = mem_q[head_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops sync_fifo on buffer credit, absorbs read
// latency, streams data as fixed-length valid/ready bursts.
// Ports: clk_i, rst_i (async, active-low), en_i; FIFO side
//        fifo_rdata_i/fifo_empty_i/fifo_error_i/fifo_rd_en_o;
//        stream m_data_o/m_valid_o/m_last_o/m_ready_i;
//        status busy_o, err_o (cleared by clr_err_i), beat_cnt_o.
module fifo_rd_stream #(
    parameter int DATA_W    = fifo_rd_pkg::DATA_W,
    parameter int BUF_DEPTH = fifo_rd_pkg::BUF_DEPTH,
    parameter int BURST_LEN = fifo_rd_pkg::BURST_LEN
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] fifo_rdata_i,
    input  logic              fifo_empty_i,
    input  logic              fifo_error_i,
    output logic              fifo_rd_en_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic              busy_o,
    output logic              err_o,
    input  logic              clr_err_i,
    output logic [15:0]       beat_cnt_o
);
    import fifo_rd_pkg::*;

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int BI_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    rd_state_e         state_q, state_d;
    logic              inflight_q, inflight_d;
    logic [BI_W-1:0]   burst_idx_q, burst_idx_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;

    logic [OCC_W-1:0]  occ;
    logic [DATA_W-1:0] head;
    logic [OCC_W:0]    credit;
    logic              valid;
    logic              accept;
    logic              rd_en;
    logic              idx_last;

    fifo_rd_skid_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i (fifo_rdata_i),
        .pop_i       (accept),
        .head_o      (head),
        .occ_o       (occ)
    );

    assign valid  = (occ != '0);
    assign accept = valid && m_ready_i;

    // Words held plus the word still on its way back from the FIFO.
    assign credit = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};

    assign rd_en = (state_q == RUN) && en_i && !fifo_empty_i
                && (credit < (OCC_W + 1)'(BUF_DEPTH));

    assign idx_last = (burst_idx_q == BI_W'(BURST_LEN - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = RUN;
            end
            RUN: begin
                if (!en_i) begin
                    if (valid || inflight_q) state_d = DRAIN;
                    else                     state_d = IDLE;
                end
            end
            DRAIN: begin
                if (en_i)
                    state_d = RUN;
                else if (!valid && !inflight_q && !accept)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d  = rd_en;
        burst_idx_d = burst_idx_q;
        beat_cnt_d  = beat_cnt_q;
        if (accept) begin
            burst_idx_d = idx_last ? '0 : burst_idx_q + 1'b1;
            beat_cnt_d  = beat_cnt_q + 1'b1;
        end
        // A new error outranks a coincident clear.
        err_d = err_q;
        if (clr_err_i)    err_d = 1'b0;
        if (fifo_error_i) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            inflight_q  <= 1'b0;
            burst_idx_q <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= inflight_d;
            burst_idx_q <= burst_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign m_valid_o    = valid;
    // Gated so the stale buffer never shows while idle or in reset.
    assign m_data_o     = valid ? head : '0;
    assign m_last_o     = valid && idx_last;
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;
    assign beat_cnt_o   = beat_cnt_q;

endmodule
